// File: rtl/compound_relay_n.sv
// compound_relay_n: round-robin N-channel relay into a FIFO gated by a FILL/FLOW/DRAIN section FSM.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous reset, active low
//   b_in         - per-channel item {mode, x, y}; channel i in slice i
//   b_in_sync    - per-channel producer valid
//   b_in_notify  - per-channel ready (one-hot at the round-robin pointer)
//   b_out        - FIFO head item, same packing as b_in
//   b_out_sync   - consumer ready
//   b_out_notify - b_out valid
//   count        - FIFO occupancy
module compound_relay_n #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 2,
    parameter int DEPTH  = 4,
    parameter int THRESH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_CH*(DATA_W+2)-1:0]        b_in,
    input  logic [N_CH-1:0]                   b_in_sync,
    output logic [N_CH-1:0]                   b_in_notify,
    output logic [DATA_W+1:0]                 b_out,
    input  logic                              b_out_sync,
    output logic                              b_out_notify,
    output logic [$clog2(DEPTH+1)-1:0]        count
);
    localparam int IW = DATA_W + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {FILL, FLOW, DRAIN} section_t;
    section_t section;
    logic [RW-1:0] rr_ptr;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] item, stored;
    logic offered, in_fire, out_fire;
    logic [CW-1:0] count_next;
    // Only the channel under the round-robin pointer is ever offered.
    assign offered      = section != DRAIN && count < CW'(DEPTH);
    assign b_in_notify  = offered ? N_CH'(1) << rr_ptr : '0;
    assign item         = b_in[rr_ptr*IW +: IW];
    assign in_fire      = offered && b_in_sync[rr_ptr];
    // Write-mode items are incremented on the way in; read-mode pass through.
    assign stored       = item[IW-1] ? {item[IW-1], item[IW-2:1] + DATA_W'(1), item[0]} : item;
    assign b_out_notify = section != FILL && count != '0;
    assign out_fire     = b_out_notify && b_out_sync;
    // Head is read from registered storage only, so b_in never reaches b_out in the same cycle.
    assign b_out        = count != '0 ? mem[rd_ptr] : '0;
    assign count_next   = count + CW'(in_fire) - CW'(out_fire);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section <= FILL;
            rr_ptr  <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (in_fire) wr_ptr <= wr_ptr + PW'(1);
            if (out_fire) rd_ptr <= rd_ptr + PW'(1);
            // Pointer moves whenever its channel was offered, taken or not.
            if (offered) rr_ptr <= rr_ptr == RW'(N_CH - 1) ? '0 : rr_ptr + RW'(1);
            count <= count_next;
            // A y=1 item forces DRAIN ahead of the threshold check.
            if (in_fire && item[0] && section != DRAIN) section <= DRAIN;
            else if (section == FILL && count_next >= CW'(THRESH)) section <= FLOW;
            else if (section != FILL && count_next == '0) section <= FILL;
        end
    end
    always_ff @(posedge clk) begin
        if (in_fire && rst) mem[wr_ptr] <= stored;
    end
endmodule

// File: tb/tb_compound_relay_n.sv
// tb_compound_relay_n: directed scoreboard bench for compound_relay_n.
module tb_compound_relay_n;
    localparam int DW = 8;
    localparam int IW = DW + 2;
    localparam int NC = 2;
    localparam int DP = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NC*IW-1:0] b_in = '0;
    logic [NC-1:0] b_in_sync = '0;
    logic [NC-1:0] b_in_notify;
    logic [IW-1:0] b_out;
    logic b_out_sync = 1'b0;
    logic b_out_notify;
    logic [2:0] count;
    int n_asrt = 0;
    int n_fail = 0;
    logic [IW-1:0] sb[$];

    always #5 clk = ~clk;

    compound_relay_n #(.DATA_W(DW), .N_CH(NC), .DEPTH(DP), .THRESH(2)) dut (
        .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(b_in_notify), .b_out(b_out), .b_out_sync(b_out_sync),
        .b_out_notify(b_out_notify), .count(count)
    );

    function automatic logic [IW-1:0] xf(input logic [IW-1:0] it);
        logic [IW-1:0] r = it;
        if (it[IW-1]) r[IW-2:1] = it[IW-2:1] + 8'd1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record transfers about to happen on the next edge, then advance one cycle.
    task automatic cycle();
        chk("notify_onehot", 32'($countones(b_in_notify) <= 1), 1);
        for (int i = 0; i < NC; i++)
            if (b_in_notify[i] && b_in_sync[i]) sb.push_back(xf(b_in[i*IW +: IW]));
        if (b_out_notify && b_out_sync) begin
            chk("pop_queued", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("b_out_item", b_out, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer0(input logic [IW-1:0] it);
        logic done = 1'b0;
        b_in[0 +: IW] = it;
        b_in_sync = 2'b01;
        for (int k = 0; k < 4 && !done; k++) begin
            done = b_in_notify[0];
            cycle();
        end
        chk("offer0_accepted", done, 1);
        b_in_sync = '0;
    endtask

    task automatic drain();
        b_out_sync = 1'b1;
        for (int k = 0; k < 8 && count != 0; k++) cycle();
        chk("drained", count, 0);
        b_out_sync = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev, cur;
        prev = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_notify", b_out_notify, 0);
        chk("rst_in_notify", b_in_notify, 2'b01);
        chk("rst_b_out", b_out, 0);
        #1 rst = 1'b1;
        #1 chk("post_rst_in_notify", b_in_notify, 2'b01);
        // First-item latency and threshold opening
        offer0({1'b1, 8'd5, 1'b0});
        chk("one_item_closed", b_out_notify, 0);
        chk("one_item_count", count, 1);
        offer0({1'b0, 8'd9, 1'b0});
        chk("thresh_open", b_out_notify, 1);
        chk("two_item_count", count, 2);
        chk("head_write5", b_out, {1'b1, 8'd6, 1'b0});
        drain();
        chk("empty_closed", b_out_notify, 0);
        // Round-robin alternation with both channels valid, filling to full
        b_in_sync = 2'b11;
        for (int k = 0; k < 4; k++) begin
            b_in = {1'b1, 8'(32'h20 + k), 1'b0, 1'b0, 8'(32'h10 + k), 1'b0};
            cur = b_in_notify[1];
            chk("rr_offered", 32'(b_in_notify != 0), 1);
            if (k > 0) chk("rr_alternate", cur, !prev);
            prev = cur;
            cycle();
        end
        chk("full_count", count, 4);
        chk("full_blocked", b_in_notify, 0);
        cycle();
        chk("full_hold_count", count, 4);
        chk("full_hold_blocked", b_in_notify, 0);
        b_out_sync = 1'b1;
        cycle();
        b_out_sync = 1'b0;
        chk("after_pop_count", count, 3);
        cycle();
        cycle();
        chk("one_more_accept", count, 4);
        chk("refull_blocked", b_in_notify, 0);
        b_in_sync = '0;
        drain();
        // y=1 item forces DRAIN from empty
        offer0({1'b0, 8'd3, 1'b1});
        chk("drain_count", count, 1);
        chk("drain_out_notify", b_out_notify, 1);
        chk("drain_in_blocked", b_in_notify, 0);
        b_in_sync = 2'b11;
        cycle();
        cycle();
        chk("drain_hold_blocked", b_in_notify, 0);
        chk("drain_hold_count", count, 1);
        b_out_sync = 1'b1;
        cycle();
        b_out_sync = 1'b0;
        b_in_sync = '0;
        chk("refill_count", count, 0);
        chk("refill_out_notify", b_out_notify, 0);
        chk("refill_in_open", 32'(b_in_notify != 0), 1);
        // x wraps to zero on write-mode increment
        offer0({1'b1, 8'hFF, 1'b0});
        chk("wrap_count", count, 1);
        offer0({1'b0, 8'h44, 1'b0});
        chk("wrap_head", b_out, {1'b1, 8'h00, 1'b0});
        drain();
        // Asynchronous reset with items queued and consumer ready
        offer0({1'b0, 8'hA1, 1'b0});
        offer0({1'b1, 8'hA2, 1'b0});
        offer0({1'b0, 8'hA3, 1'b0});
        chk("pre_rst_count", count, 3);
        chk("pre_rst_out_notify", b_out_notify, 1);
        b_out_sync = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_out_notify", b_out_notify, 0);
        chk("async_rst_in_notify", b_in_notify, 2'b01);
        chk("async_rst_b_out", b_out, 0);
        sb.delete();
        cycle();
        cycle();
        chk("in_rst_no_pop", b_out_notify, 0);
        rst = 1'b1;
        cycle();
        cycle();
        chk("post_rst_count", count, 0);
        chk("post_rst_out_notify", b_out_notify, 0);
        b_out_sync = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
